// File: rtl/controle_vedacao_if.sv
`default_nettype none
// ============================================================================
//  Module      : controle_vedacao_if
//  Description : Signal bundle between the corking-station controller and its
//                environment (bottle sensor, cork counter, press, display).
//  Revision    : 1.0 - initial release
// ============================================================================
interface controle_vedacao_if #(
    parameter int W_CONT = 8
);
    logic              start_proc;
    logic              garrafa_presente;
    logic              rolha_disponivel;
    logic              disp_acionado;
    logic              dec;
    logic              atuador;
    logic              garrafa_liberada;
    logic              alarme_sem_rolha;
    logic [W_CONT-1:0] garrafas_vedadas;
    logic [2:0]        estado;

    // Controller side: consumes sensor/counter status, drives requests.
    modport master (
        input  start_proc,
        input  garrafa_presente,
        input  rolha_disponivel,
        input  disp_acionado,
        output dec,
        output atuador,
        output garrafa_liberada,
        output alarme_sem_rolha,
        output garrafas_vedadas,
        output estado
    );

    // Environment side: the mirror image of the controller.
    modport slave (
        output start_proc,
        output garrafa_presente,
        output rolha_disponivel,
        output disp_acionado,
        input  dec,
        input  atuador,
        input  garrafa_liberada,
        input  alarme_sem_rolha,
        input  garrafas_vedadas,
        input  estado
    );
endinterface
`default_nettype wire

// File: rtl/controle_vedacao.sv
`default_nettype none
// ============================================================================
//  Module      : controle_vedacao
//  Description : Corking-station controller. Waits for a bottle, requests one
//                cork from the cork counter, drives the press for a fixed time,
//                releases the bottle and keeps a saturating sealed count.
//                Every output comes straight from a register.
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_vedacao #(
    parameter int PRESS_CICLOS = 4,
    parameter int ESPERA_MAX   = 20,
    parameter int W_CONT       = 8
) (
    input  logic               clk,
    input  logic               reset,
    controle_vedacao_if.master bus
);

    localparam int c_W_ESPERA = $clog2(ESPERA_MAX + 1);
    localparam int c_W_PRENSA = (PRESS_CICLOS > 1) ? $clog2(PRESS_CICLOS) : 1;

    localparam logic [c_W_ESPERA-1:0] c_ESPERA_MAX    = c_W_ESPERA'(ESPERA_MAX);
    localparam logic [c_W_ESPERA-1:0] c_ESPERA_PENULT = c_W_ESPERA'(ESPERA_MAX - 1);
    localparam logic [c_W_ESPERA-1:0] c_ESPERA_UM     = c_W_ESPERA'(1);
    localparam logic [c_W_PRENSA-1:0] c_PRENSA_FIM    = c_W_PRENSA'(PRESS_CICLOS - 1);
    localparam logic [c_W_PRENSA-1:0] c_PRENSA_UM     = c_W_PRENSA'(1);
    localparam logic [W_CONT-1:0]     c_CONT_UM       = W_CONT'(1);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        AGUARDA  = 3'd1,
        SOLICITA = 3'd2,
        PRENSA   = 3'd3,
        LIBERA   = 3'd4
    } estado_t;

    estado_t               r_estado;
    logic [c_W_ESPERA-1:0] r_timer_espera;
    logic [c_W_PRENSA-1:0] r_timer_prensa;
    logic [W_CONT-1:0]     r_cont;
    logic                  r_dec;
    logic                  r_atuador;
    logic                  r_liberada;
    logic                  r_alarme;

    // Sequencer: state, timers, sealed count and all registered outputs.
    // Each output is loaded with the value it must have in the state being
    // entered, so the pins change exactly on the state-changing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado       <= OCIOSO;
            r_timer_espera <= '0;
            r_timer_prensa <= '0;
            r_cont         <= '0;
            r_dec          <= 1'b0;
            r_atuador      <= 1'b0;
            r_liberada     <= 1'b0;
            r_alarme       <= 1'b0;
        end else if (bus.start_proc) begin
            r_estado       <= OCIOSO;
            r_timer_espera <= '0;
            r_timer_prensa <= '0;
            r_cont         <= '0;
            r_dec          <= 1'b0;
            r_atuador      <= 1'b0;
            r_liberada     <= 1'b0;
            r_alarme       <= 1'b0;
        end else begin
            r_dec      <= 1'b0;
            r_atuador  <= 1'b0;
            r_liberada <= 1'b0;
            r_alarme   <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    r_timer_espera <= '0;
                    if (bus.garrafa_presente) begin
                        r_estado <= AGUARDA;
                    end
                end
                AGUARDA: begin
                    if (!bus.garrafa_presente) begin
                        r_estado <= OCIOSO;
                    end else if (bus.rolha_disponivel && !bus.disp_acionado) begin
                        r_estado <= SOLICITA;
                        r_dec    <= 1'b1;
                    end else begin
                        // Alarm follows the timer value being written now.
                        if (r_timer_espera != c_ESPERA_MAX) begin
                            r_timer_espera <= r_timer_espera + c_ESPERA_UM;
                        end
                        r_alarme <= (r_timer_espera >= c_ESPERA_PENULT);
                    end
                end
                SOLICITA: begin
                    // The cork request has been issued; press unconditionally.
                    r_estado       <= PRENSA;
                    r_timer_prensa <= '0;
                    r_atuador      <= 1'b1;
                end
                PRENSA: begin
                    // Sensor is deliberately ignored: a started press completes.
                    if (r_timer_prensa == c_PRENSA_FIM) begin
                        r_estado   <= LIBERA;
                        r_liberada <= 1'b1;
                        if (r_cont != {W_CONT{1'b1}}) begin
                            r_cont <= r_cont + c_CONT_UM;
                        end
                    end else begin
                        r_timer_prensa <= r_timer_prensa + c_PRENSA_UM;
                        r_atuador      <= 1'b1;
                    end
                end
                LIBERA: begin
                    // Hold until the bottle leaves so it is never corked twice.
                    if (!bus.garrafa_presente) begin
                        r_estado <= OCIOSO;
                    end
                end
                default: begin
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.dec              = r_dec;
    assign bus.atuador          = r_atuador;
    assign bus.garrafa_liberada = r_liberada;
    assign bus.alarme_sem_rolha = r_alarme;
    assign bus.garrafas_vedadas = r_cont;
    assign bus.estado           = r_estado;

endmodule
`default_nettype wire
